mul_unit_mc: RTL and testbench
==============================

// Module: mul_unit_mc
// PURPOSE
//  Parametrised iterative multiply/multiply-accumulate unit for the multicycle core.
//  Replaces the single-cycle combinational multiply path in the ALU.
//  Supports MUL, MLA, UMULL, UMLAL, SMULL and SMLAL with a start/busy/done handshake.
//  The controller FSM stalls in an execute-wait state until done, then writes result_lo/result_hi back.
// PARAMETERS
//  WIDTH        32  operand width; long results are 2*WIDTH bits
//  RADIX_BITS   1   multiplier bits retired per cycle (1, 2 or 4); WIDTH % RADIX_BITS == 0
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  start      in   1          request; accepted only on a rising edge where busy==0
//  op         in   3          000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL (others = MUL)
//  a          in   WIDTH      multiplicand (Rm)
//  b          in   WIDTH      multiplier (Rs)
//  acc        in   2*WIDTH    accumulate value: MLA uses acc[WIDTH-1:0]; *MLAL uses all bits {RdHi,RdLo}
//  busy       out  1          high from the accepting edge until the edge that raises done
//  done       out  1          single-cycle pulse; result_* valid from that edge
//  result_lo  out  WIDTH      low result word (Rd for short ops, RdLo for long ops)
//  result_hi  out  WIDTH      high word for long ops; 0 for short ops
//  flag_n     out  1          N flag: MSB of result_hi (long) or of result_lo (short)
//  flag_z     out  1          Z flag: full 2*WIDTH result == 0 (long) or result_lo == 0 (short)
// BEHAVIOUR
//  - reset low (any time, asynchronous): state IDLE; busy, done, result_lo, result_hi, flag_n,
//    flag_z, and all internal registers cleared to 0. An in-flight operation is abandoned; no done.
//  - FSM: IDLE -> CALC on an accepted start. CALC stays for N = WIDTH/RADIX_BITS cycles; a down-counter
//    is loaded with N-1 and CALC exits when it reads 0. CALC -> FIX for one cycle. FIX -> IDLE.
//  - Accepting edge: a, b, op, and acc are captured. Later input changes have no effect.
//    Signed ops (op[2:1]==11): store |a| and |b| plus sign = a[MSB]^b[MSB]. Other ops: raw values.
//  - CALC: each cycle adds multiplicand*b[RADIX_BITS-1:0] into a 2*WIDTH product register, then shifts b
//    right and the multiplicand left by RADIX_BITS. Unsigned arithmetic only; carries are kept.
//  - FIX: product is negated (two's complement, 2*WIDTH) if sign==1.
//    acc is added when op[0]==1: 2*WIDTH for long ops, WIDTH for MLA.
//    Result is truncated to WIDTH for short ops. result_*, flag_n and flag_z register on FIX's exit edge.
//  - Latency: done is high in the cycle after the (N+1)th rising edge following the accepting edge.
//    Equivalently, done rises N+1 edges after acceptance; busy falls on that same edge.
//    WIDTH=32, RADIX_BITS=1 gives 33 cycles; RADIX_BITS=4 gives 9.
//  - start while busy==1 is ignored, not queued. start on the edge done is high (busy==0) is accepted,
//    giving back-to-back operation.
//  - Results and flags hold until the FIX of the next operation. done is low except for its 1-cycle pulse.
//  - Signed corner: a = b = most-negative value is handled without overflow. Magnitudes use WIDTH+1-bit
//    unsigned, or equivalently the 2*WIDTH product register absorbs 2^(2*WIDTH-2).
//  - Accumulate wraps modulo 2^(2*WIDTH) (long) or 2^WIDTH (MLA); there is no saturation and no carry
//    or overflow flag.
// TESTING
//  1. UMULL a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 N=1 Z=0; done exactly 33 cycles after accept.
//  2. SMULL a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0x00000000 N=0 Z=0.
//     SMULL a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1 N=1.
//  3. MLA a=7 b=6 acc=0x_xxxxxxxx_FFFFFFD6 -> lo=0x00000000 hi=0 Z=1 N=0.
//     SMLAL a=2 b=-1 acc=2 -> {hi,lo}=0 Z=1.
//  4. start pulsed during busy with different operands -> ignored; first result returned.
//     start on the done edge -> second op accepted; its done comes 33 cycles later.
//  5. reset low mid-CALC (cycle 10) -> busy/done/results 0 immediately.
//     After release, IDLE, and a fresh MUL 3*4 -> lo=12.
//  6. Re-run 1-3 with RADIX_BITS=2 and 4 (latency 17 and 9 cycles).
//     Random 1k-op sweep vs reference model at WIDTH=8 and 32.

Source files
------------

// File: rtl/mul_unit_mc.sv
// -----------------------------------------------------------------------------
// mul_unit_mc
//   Iterative multiply / multiply-accumulate unit for the multicycle core.
//   Handles MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. RADIX_BITS multiplier bits
//   are retired per cycle, so an operation takes WIDTH/RADIX_BITS CALC cycles
//   plus one FIX cycle. The result appears with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request, accepted on a rising edge while busy == 0
//   op         000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL,
//              any other encoding behaves as MUL
//   a          multiplicand (Rm)
//   b          multiplier (Rs)
//   acc        accumulate value {RdHi,RdLo}; MLA uses only the low word
//   busy       high from the accepting edge until the edge that raises done
//   done       single-cycle pulse, result_* valid from that edge
//   result_lo  low result word (Rd for short ops, RdLo for long ops)
//   result_hi  high result word for long ops, 0 for short ops
//   flag_n     sign bit of the architectural result
//   flag_z     architectural result is zero
// -----------------------------------------------------------------------------
module mul_unit_mc #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   acc,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result_lo,
  output logic [WIDTH-1:0]     result_hi,
  output logic                 flag_n,
  output logic                 flag_z
);

  localparam int W2 = 2 * WIDTH;
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   mcand;     // multiplicand magnitude, shifted left each CALC cycle
  logic [WIDTH-1:0] mplier;   // multiplier magnitude, shifted right each CALC cycle
  logic [W2-1:0]   prod;      // unsigned partial-product accumulator
  logic [W2-1:0]   acc_q;     // accumulate term, already masked for the op
  logic            is_long;
  logic            neg;       // product must be negated in FIX

  // Decode of the live inputs, only meaningful on the accepting edge.
  logic            in_long;
  logic            in_acc;
  logic            in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]   acc_sel;
  // Datapath terms for CALC and FIX.
  logic [W2-1:0]   step;
  logic [W2-1:0]   prod_fix;
  logic [W2-1:0]   fix_val;

  // NOTE: every signal driven here gets a value on every path (defaults first),
  // otherwise synthesis infers a latch.
  always_comb begin
    in_long   = op[2];
    in_signed = op[2] & op[1];
    // MLA (001) and the long accumulate forms; 011 decodes as plain MUL.
    in_acc    = op[0] & (op[2] | ~op[1]);

    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1), so WIDTH bits are enough here.
    a_mag = (in_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (in_signed && b[WIDTH-1]) ? -b : b;

    acc_sel = '0;
    if (in_acc) begin
      acc_sel = in_long ? acc : {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    end

    step     = mcand * W2'(mplier[RADIX_BITS-1:0]);
    prod_fix = neg ? -prod : prod;
    // Wraps modulo 2^W2; short ops only look at the low word afterwards.
    fix_val  = prod_fix + acc_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // asynchronous reset clears every register (there is no memory here), so an
  // abandoned operation can never leak a done pulse or stale result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      acc_q     <= '0;
      is_long   <= 1'b0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            prod    <= '0;
            acc_q   <= acc_sel;
            is_long <= in_long;
            neg     <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end

        CALC: begin
          prod   <= prod + step;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        FIX: begin
          result_lo <= fix_val[WIDTH-1:0];
          if (is_long) begin
            result_hi <= fix_val[W2-1:WIDTH];
            flag_n    <= fix_val[W2-1];
            flag_z    <= (fix_val == '0);
          end else begin
            result_hi <= '0;
            flag_n    <= fix_val[WIDTH-1];
            flag_z    <= (fix_val[WIDTH-1:0] == '0);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_mul_unit_mc
//   Self-checking bench for mul_unit_mc. Three instances are exercised one at
//   a time: WIDTH=32/RADIX_BITS=1, WIDTH=32/RADIX_BITS=4 and WIDTH=8/RADIX_BITS=2.
//   Expected results are pushed to a scoreboard queue when an operation is
//   issued and popped when done is seen. Random operations use a reference
//   model built on full-width sign-extended multiplication.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_unit_mc;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  // WIDTH=32, RADIX_BITS=1
  logic        r1_start, r1_busy, r1_done, r1_n, r1_z;
  logic [2:0]  r1_op;
  logic [31:0] r1_a, r1_b, r1_lo, r1_hi;
  logic [63:0] r1_acc;
  // WIDTH=32, RADIX_BITS=4
  logic        r4_start, r4_busy, r4_done, r4_n, r4_z;
  logic [2:0]  r4_op;
  logic [31:0] r4_a, r4_b, r4_lo, r4_hi;
  logic [63:0] r4_acc;
  // WIDTH=8, RADIX_BITS=2
  logic        w8_start, w8_busy, w8_done, w8_n, w8_z;
  logic [2:0]  w8_op;
  logic [7:0]  w8_a, w8_b, w8_lo, w8_hi;
  logic [15:0] w8_acc;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_unit_mc #(.WIDTH(32), .RADIX_BITS(1)) dut_r1 (
    .clk(clk), .reset(reset), .start(r1_start), .op(r1_op), .a(r1_a), .b(r1_b),
    .acc(r1_acc), .busy(r1_busy), .done(r1_done), .result_lo(r1_lo),
    .result_hi(r1_hi), .flag_n(r1_n), .flag_z(r1_z)
  );

  mul_unit_mc #(.WIDTH(32), .RADIX_BITS(4)) dut_r4 (
    .clk(clk), .reset(reset), .start(r4_start), .op(r4_op), .a(r4_a), .b(r4_b),
    .acc(r4_acc), .busy(r4_busy), .done(r4_done), .result_lo(r4_lo),
    .result_hi(r4_hi), .flag_n(r4_n), .flag_z(r4_z)
  );

  mul_unit_mc #(.WIDTH(8), .RADIX_BITS(2)) dut_w8 (
    .clk(clk), .reset(reset), .start(w8_start), .op(w8_op), .a(w8_a), .b(w8_b),
    .acc(w8_acc), .busy(w8_busy), .done(w8_done), .result_lo(w8_lo),
    .result_hi(w8_hi), .flag_n(w8_n), .flag_z(w8_z)
  );

  // ---------------------------------------------------------------------------
  // Instance access helpers (sel: 0 = r1, 1 = r4, 2 = w8)
  // ---------------------------------------------------------------------------
  function automatic int lat_of(input int sel);
    return (sel == 0) ? 33 : (sel == 1) ? 9 : 5;
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 2) ? 8 : 32;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? r1_busy : (sel == 1) ? r4_busy : w8_busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? r1_done : (sel == 1) ? r4_done : w8_done;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc);
    case (sel)
      0: begin r1_start = st; r1_op = op; r1_a = a; r1_b = b; r1_acc = acc; end
      1: begin r4_start = st; r4_op = op; r4_a = a; r4_b = b; r4_acc = acc; end
      default: begin
        w8_start = st; w8_op = op; w8_a = a[7:0]; w8_b = b[7:0]; w8_acc = acc[15:0];
      end
    endcase
  endtask

  task automatic get_out(input int sel, output exp_t got);
    case (sel)
      0: got = '{lo: r1_lo, hi: r1_hi, n: r1_n, z: r1_z};
      1: got = '{lo: r4_lo, hi: r4_hi, n: r4_n, z: r4_z};
      default: got = '{lo: {24'b0, w8_lo}, hi: {24'b0, w8_hi}, n: w8_n, z: w8_z};
    endcase
  endtask

  // Reference model: sign-extend to 128 bits, multiply, accumulate, mask.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] acc);
    logic [127:0] mw, ml, ea, eb, p;
    bit sgn, lng, ac;
    exp_t e;
    sgn = 0; lng = 0; ac = 0;
    case (op)
      3'b001: ac = 1;
      3'b100: lng = 1;
      3'b101: begin lng = 1; ac = 1; end
      3'b110: begin lng = 1; sgn = 1; end
      3'b111: begin lng = 1; sgn = 1; ac = 1; end
      default: ;
    endcase
    mw = (128'd1 << w) - 128'd1;
    ml = (128'd1 << (2 * w)) - 128'd1;
    ea = {96'b0, a} & mw;
    eb = {96'b0, b} & mw;
    if (sgn && a[w-1]) ea = ea | ~mw;
    if (sgn && b[w-1]) eb = eb | ~mw;
    p = ea * eb;
    if (ac) p = p + ({64'b0, acc} & (lng ? ml : mw));
    if (lng) begin
      p    = p & ml;
      e.lo = 32'(p & mw);
      e.hi = 32'((p >> w) & mw);
      e.n  = p[2*w-1];
      e.z  = (p == 128'd0);
    end else begin
      p    = p & mw;
      e.lo = 32'(p);
      e.hi = 32'd0;
      e.n  = p[w-1];
      e.z  = (p == 128'd0);
    end
    return e;
  endfunction

  // Called just after a negedge; the following posedge accepts the request.
  // Inputs are scrambled right after acceptance to prove they were captured.
  task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] acc, input exp_t e);
    sb.push_back(e);
    set_in(sel, 1'b1, op, a, b, acc);
    @(negedge clk);
    set_in(sel, 1'b0, ~op, ~a, b ^ 32'h5a5a_5a5a, ~acc);
    total++;
    if (busy_of(sel) !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept sel=%0d got=%b want=1", sel, busy_of(sel));
    end
  endtask

  // elapsed = negedges already waited since the one following the accept edge.
  task automatic wait_done(input int sel, input int elapsed, input string name);
    int   cyc;
    exp_t e, got;
    cyc = elapsed;
    while (done_of(sel) !== 1'b1 && cyc < lat_of(sel) + 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== lat_of(sel)) begin
      bad++;
      $display("FAIL %s latency sel=%0d got=%0d want=%0d", name, sel, cyc, lat_of(sel));
    end
    total++;
    if (busy_of(sel) !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done sel=%0d got=%b want=0", name, sel, busy_of(sel));
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard_empty sel=%0d", name, sel);
    end else begin
      e = sb.pop_front();
      get_out(sel, got);
      if (got !== e) begin
        bad++;
        $display("FAIL %s result sel=%0d got hi=%h lo=%h n=%b z=%b want hi=%h lo=%h n=%b z=%b",
                 name, sel, got.hi, got.lo, got.n, got.z, e.hi, e.lo, e.n, e.z);
      end
    end
  endtask

  task automatic run_exp(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] acc,
                         input exp_t e, input string name);
    @(negedge clk);
    issue(sel, op, a, b, acc, e);
    wait_done(sel, 0, name);
  endtask

  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input string name);
    run_exp(sel, op, a, b, acc, model(width_of(sel), op, a, b, acc), name);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 8) ? 32'hff : 32'hffff_ffff;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return m;
      2: return (w == 8) ? 32'h80 : 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t got;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 3'b000, 32'd0, 32'd0, 64'd0);
    #12;
    for (int s = 0; s < 3; s++) begin
      get_out(s, got);
      total++;
      if ({busy_of(s), done_of(s), got} !== '0) begin
        bad++;
        $display("FAIL reset_state sel=%0d got busy=%b done=%b out=%h want all 0",
                 s, busy_of(s), done_of(s), got);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed(input int sel);
    run_exp(sel, 3'b100, 32'hffff_ffff, 32'hffff_ffff, 64'd0,
            '{lo: 32'h0000_0001, hi: 32'hffff_fffe, n: 1'b1, z: 1'b0}, "umull_max");
    run_exp(sel, 3'b110, 32'h8000_0000, 32'h8000_0000, 64'd0,
            '{lo: 32'h0, hi: 32'h4000_0000, n: 1'b0, z: 1'b0}, "smull_minneg");
    run_exp(sel, 3'b110, 32'hffff_fffd, 32'd5, 64'd0,
            '{lo: 32'hffff_fff1, hi: 32'hffff_ffff, n: 1'b1, z: 1'b0}, "smull_neg");
    run_exp(sel, 3'b001, 32'd7, 32'd6, 64'h1234_5678_ffff_ffd6,
            '{lo: 32'h0, hi: 32'h0, n: 1'b0, z: 1'b1}, "mla_wrap");
    run_exp(sel, 3'b111, 32'd2, 32'hffff_ffff, 64'd2,
            '{lo: 32'h0, hi: 32'h0, n: 1'b0, z: 1'b1}, "smlal_zero");
    run_exp(sel, 3'b101, 32'hffff_ffff, 32'hffff_ffff, 64'hffff_ffff_ffff_ffff,
            '{lo: 32'h0, hi: 32'hffff_fffe, n: 1'b1, z: 1'b0}, "umlal_wrap");
    run_exp(sel, 3'b010, 32'h0001_0000, 32'h0001_0000, 64'd5,
            '{lo: 32'h0, hi: 32'h0, n: 1'b0, z: 1'b1}, "op010_as_mul");
    run_exp(sel, 3'b000, 32'h8000_0000, 32'd1, 64'd0,
            '{lo: 32'h8000_0000, hi: 32'h0, n: 1'b1, z: 1'b0}, "mul_neg_flag");
  endtask

  task automatic test_back_to_back(input int sel);
    @(negedge clk);
    issue(sel, 3'b100, 32'hffff_ffff, 32'hffff_ffff, 64'd0,
          '{lo: 32'h1, hi: 32'hffff_fffe, n: 1'b1, z: 1'b0});
    wait_done(sel, 0, "b2b_first");
    // Still on the negedge where done is high: the next posedge accepts.
    issue(sel, 3'b000, 32'd3, 32'd4, 64'd0,
          '{lo: 32'd12, hi: 32'd0, n: 1'b0, z: 1'b0});
    wait_done(sel, 0, "b2b_second");
  endtask

  task automatic test_busy_ignore();
    bit seen;
    @(negedge clk);
    issue(0, 3'b100, 32'hffff_ffff, 32'hffff_ffff, 64'd0,
          '{lo: 32'h1, hi: 32'hffff_fffe, n: 1'b1, z: 1'b0});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      set_in(0, (i == 3 || i == 7), 3'b000, 32'd3, 32'd3, 64'd0);
    end
    set_in(0, 1'b0, 3'b000, 32'd3, 32'd3, 64'd0);
    wait_done(0, 10, "busy_ignore");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (r1_done !== 1'b0 || r1_busy !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL busy_ignore_no_second_op got activity=1 want=0");
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    @(negedge clk);
    issue(0, 3'b100, 32'h0001_2345, 32'h0000_6789, 64'd0,
          model(32, 3'b100, 32'h0001_2345, 32'h0000_6789, 64'd0));
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({r1_busy, r1_done, r1_lo, r1_hi, r1_n, r1_z} !== '0) begin
      bad++;
      $display("FAIL reset_mid_calc got busy=%b done=%b hi=%h lo=%h n=%b z=%b want all 0",
               r1_busy, r1_done, r1_hi, r1_lo, r1_n, r1_z);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (r1_done !== 1'b0 || r1_busy !== 1'b0 || r1_lo !== 32'd0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_abandons_op got activity=1 want=0");
    end
    run_exp(0, 3'b000, 32'd3, 32'd4, 64'd0,
            '{lo: 32'd12, hi: 32'd0, n: 1'b0, z: 1'b0}, "mul_after_reset");
  endtask

  task automatic test_random(input int sel, input int count);
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] acc;
    for (int i = 0; i < count; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick(width_of(sel));
      b   = pick(width_of(sel));
      acc = {$urandom, $urandom};
      run_op(sel, op, a, b, acc, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_busy_ignore();
    test_reset_mid_op();
    test_random(0, 150);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
